// File: rtl/click_if.sv
// Handshake bundle between the press source / event consumer and click_classifier.
interface click_if;
  logic       pressed;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_code;
  logic       overflow;
  logic       clr_ovf;

  modport master (
    output pressed,
    output evt_ready,
    output clr_ovf,
    input  evt_valid,
    input  evt_code,
    input  overflow
  );

  modport slave (
    input  pressed,
    input  evt_ready,
    input  clr_ovf,
    output evt_valid,
    output evt_code,
    output overflow
  );
endinterface

// File: rtl/click_classifier.sv
// Groups debounced press pulses into single/double/triple gestures and presents
// each gesture as a held valid/ready event with a sticky drop indicator.
module click_classifier #(
  parameter int unsigned WINDOW_CYCLES = 500000
) (
  input  logic    clk,
  input  logic    rst_n,
  click_if.slave  bus
);

  localparam int unsigned TW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [TW-1:0] T_ZERO = TW'(0);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [1:0]    count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          evt_valid_q, evt_valid_d;
  logic [1:0]    evt_code_q, evt_code_d;
  logic          overflow_q, overflow_d;

  logic          emit_s;
  logic [1:0]    emit_code_s;
  logic          accept_s;

  assign accept_s = evt_valid_q && bus.evt_ready;

  // Gesture FSM plus event/overflow next-state.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    timer_d     = timer_q;
    emit_s      = 1'b0;
    emit_code_s = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (bus.pressed) begin
          state_d = S_WAIT;
          count_d = 2'd1;
          timer_d = T_ZERO;
        end else begin
          timer_d = T_ZERO;
        end
      end
      S_WAIT: begin
        // A press outranks a coinciding timeout: it extends the gesture.
        if (bus.pressed) begin
          if (count_q == 2'd2) begin
            emit_s      = 1'b1;
            emit_code_s = 2'b11;
            state_d     = S_IDLE;
            count_d     = 2'd0;
            timer_d     = T_ZERO;
          end else begin
            count_d = count_q + 2'd1;
            timer_d = T_ZERO;
          end
        end else if (timer_q == T_LAST) begin
          emit_s      = 1'b1;
          emit_code_s = count_q;
          state_d     = S_IDLE;
          count_d     = 2'd0;
          timer_d     = T_ZERO;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = 2'd0;
        timer_d = T_ZERO;
      end
    endcase

    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    overflow_d  = overflow_q;
    if (emit_s && (!evt_valid_q || bus.evt_ready)) begin
      evt_valid_d = 1'b1;
      evt_code_d  = emit_code_s;
    end else if (accept_s) begin
      evt_valid_d = 1'b0;
    end else begin
      evt_valid_d = evt_valid_q;
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (emit_s && evt_valid_q && !bus.evt_ready) begin
      overflow_d = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= 2'd0;
      timer_q     <= T_ZERO;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 2'b00;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_code  = evt_code_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_click_classifier.sv
// Directed, table-driven bench for click_classifier with an 8-cycle window.
module tb_click_classifier;

  typedef struct {
    logic       p;
    logic       r;
    logic       c;
    logic       ev;
    logic [1:0] ec;
    logic       eo;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs[$];

  click_if bus ();

  click_classifier #(.WINDOW_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(logic p, logic r, logic c, logic ev, logic [1:0] ec, logic eo);
    vec_t v;
    v.p = p; v.r = r; v.c = c; v.ev = ev; v.ec = ec; v.eo = eo;
    vecs.push_back(v);
  endfunction

  function automatic void idle(int n, logic r, logic ev, logic [1:0] ec, logic eo);
    for (int k = 0; k < n; k++) add(1'b0, r, 1'b0, ev, ec, eo);
  endfunction

  task automatic check(string name, logic ev, logic [1:0] ec, logic eo);
    checks++;
    if (bus.evt_valid !== ev || (ev && bus.evt_code !== ec) || bus.overflow !== eo) begin
      errors++;
      $display("FAIL %s: got valid=%0b code=%b ovf=%0b, want valid=%0b code=%b ovf=%0b",
               name, bus.evt_valid, bus.evt_code, bus.overflow, ev, ec, eo);
    end
  endtask

  task automatic step(logic p, logic r, logic c);
    @(negedge clk);
    bus.pressed   = p;
    bus.evt_ready = r;
    bus.clr_ovf   = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.pressed = 1'b0;
    bus.evt_ready = 1'b1;
    bus.clr_ovf = 1'b0;

    // single press
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    idle(7, 1'b1, 1'b0, 2'b00, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
    idle(1, 1'b1, 1'b0, 2'b00, 1'b0);
    // double: presses at E0 and E0+5
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    idle(4, 1'b1, 1'b0, 2'b00, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    idle(7, 1'b1, 1'b0, 2'b00, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    idle(1, 1'b1, 1'b0, 2'b00, 1'b0);
    // triple at E0, E0+3, E0+6 then new gesture at E0+7
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    idle(2, 1'b1, 1'b0, 2'b00, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    idle(2, 1'b1, 1'b0, 2'b00, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    idle(7, 1'b1, 1'b0, 2'b00, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
    idle(1, 1'b1, 1'b0, 2'b00, 1'b0);
    // second press coincides with the timeout edge
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    idle(7, 1'b1, 1'b0, 2'b00, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    idle(7, 1'b1, 1'b0, 2'b00, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    idle(1, 1'b1, 1'b0, 2'b00, 1'b0);
    // ready low: first event held, second dropped, then clear
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    idle(7, 1'b0, 1'b0, 2'b00, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    idle(11, 1'b0, 1'b1, 2'b01, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    idle(7, 1'b0, 1'b1, 2'b01, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    // emit on the acceptance edge replaces the event without overflow
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    idle(7, 1'b0, 1'b0, 2'b00, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    idle(4, 1'b0, 1'b1, 2'b01, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    idle(7, 1'b0, 1'b1, 2'b01, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    idle(1, 1'b1, 1'b0, 2'b00, 1'b0);
    // drop coinciding with clr_ovf keeps overflow set
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    idle(7, 1'b0, 1'b0, 2'b00, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    idle(7, 1'b0, 1'b1, 2'b01, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    // held level counts once per cycle: three edges make a triple
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.evt_valid !== 1'b0 || bus.evt_code !== 2'b00 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%0b code=%b ovf=%0b, want 0 00 0",
               bus.evt_valid, bus.evt_code, bus.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].p, vecs[i].r, vecs[i].c);
      check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].eo);
    end

    // reset with a pending event, overflow and a gesture in flight
    step(1'b1, 1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("pend_before_rst", 1'b1, 2'b01, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("ovf_before_rst", 1'b1, 2'b01, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.evt_valid !== 1'b0 || bus.evt_code !== 2'b00 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got valid=%0b code=%b ovf=%0b, want 0 00 0",
               bus.evt_valid, bus.evt_code, bus.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.evt_ready = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
        step(1'b0, 1'b1, 1'b0);
        if (bus.evt_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
        errors++;
        $display("FAIL no_evt_after_rst: got %0d valid cycles, want 0", seen);
      end
    end

    // press on the very first edge after reset release
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    check("first_edge_press", 1'b0, 2'b00, 1'b0);
    repeat (7) step(1'b0, 1'b1, 1'b0);
    check("first_edge_pre", 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("first_edge_evt", 1'b1, 2'b01, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("first_edge_ack", 1'b0, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
